// File: rtl/req_priority_encoder.sv
// Sticky request collector that presents one pending request index at a time on a
// valid/ready handshake, with fixed-priority or round-robin selection.
module req_priority_encoder #(
  parameter int N           = 8,
  parameter int W           = $clog2(N),
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [W-1:0] code,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t       state, state_next;
  logic [W-1:0] ptr, ptr_next;
  logic [W-1:0] code_next;
  logic [N-1:0] pending_next;
  logic [N-1:0] served;
  logic [N-1:0] remaining;
  logic         accept;

  // Scan starts at base; N is a power of two so the W-bit index wraps N-1 -> 0 for free.
  function automatic logic [W-1:0] sel(input logic [N-1:0] v, input logic [W-1:0] base);
    logic [W-1:0] idx;
    logic         found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = ROUND_ROBIN ? base + W'(i) : W'(i);
      if (!found && v[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    state_next   = state;
    code_next    = code;
    ptr_next     = ptr;
    served       = '0;
    accept       = (state == PRESENT) && ready;
    served[code] = accept;
    remaining    = pending & ~served;
    pending_next = remaining | req;

    case (state)
      IDLE: begin
        if (|pending) begin
          state_next = PRESENT;
          code_next  = sel(pending, ptr);
        end
      end
      PRESENT: begin
        // Requests landing on the accept edge are not in remaining; they join next cycle.
        if (ready) begin
          ptr_next = code + W'(1);
          if (|remaining) code_next = sel(remaining, code + W'(1));
          else            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values and the
    // result does not depend on the order in which always blocks are evaluated.
    if (rst) begin
      state   <= IDLE;
      code    <= '0;
      ptr     <= '0;
      pending <= '0;
    end else begin
      state   <= state_next;
      code    <= code_next;
      ptr     <= ptr_next;
      pending <= pending_next;
    end
  end

  assign valid = (state == PRESENT);

endmodule

// File: tb/tb_req_priority_encoder.sv
// Directed bench for req_priority_encoder: one fixed-priority and one round-robin instance,
// expected codes queued at stimulus time and popped on each accepted handshake.
module tb_req_priority_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] fix_req, rr_req;
  logic       fix_ready, rr_ready;
  logic [2:0] fix_code, rr_code;
  logic       fix_valid, rr_valid;
  logic [7:0] fix_pending, rr_pending;

  int vectors;
  int miscompares;
  int exp_q[$];
  int cycles;

  req_priority_encoder #(.N(8), .W(3), .ROUND_ROBIN(1'b0)) u_fix (
    .clk(clk), .rst(rst), .req(fix_req), .code(fix_code),
    .valid(fix_valid), .ready(fix_ready), .pending(fix_pending)
  );

  req_priority_encoder #(.N(8), .W(3), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .req(rr_req), .code(rr_code),
    .valid(rr_valid), .ready(rr_ready), .pending(rr_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drain(input bit use_rr, input int budget, output int used);
    logic       v, r;
    logic [2:0] c;
    int         exp;
    used = 0;
    while (exp_q.size() != 0 && used < budget) begin
      v = use_rr ? rr_valid : fix_valid;
      r = use_rr ? rr_ready : fix_ready;
      c = use_rr ? rr_code  : fix_code;
      if (v && r) begin
        exp = exp_q.pop_front();
        check(use_rr ? "rr_code" : "fix_code", 32'(c), 32'(exp));
      end
      tick();
      used++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    fix_req   = 8'hFF;
    rr_req    = 8'h00;
    fix_ready = 1'b0;
    rr_ready  = 1'b0;

    // 1. Reset discards requests sampled during reset
    tick();
    tick();
    check("rst_pending", 32'(fix_pending), 32'h00);
    check("rst_valid",   32'(fix_valid),   32'h0);
    check("rst_code",    32'(fix_code),    32'h0);
    check("rst_rr_valid", 32'(rr_valid),   32'h0);
    rst     = 1'b0;
    fix_req = 8'h00;
    tick();
    check("post_rst_valid1", 32'(fix_valid), 32'h0);
    tick();
    check("post_rst_valid2", 32'(fix_valid), 32'h0);

    // 2. Single request, two-cycle latency
    fix_req   = 8'b0010_0000;
    fix_ready = 1'b1;
    tick();
    fix_req = 8'h00;
    check("single_pending", 32'(fix_pending), 32'h20);
    check("single_valid_early", 32'(fix_valid), 32'h0);
    tick();
    check("single_valid", 32'(fix_valid), 32'h1);
    check("single_code",  32'(fix_code),  32'd5);
    tick();
    check("single_done_pending", 32'(fix_pending), 32'h00);
    check("single_done_valid",   32'(fix_valid),   32'h0);

    // 3. Fixed-priority backlog drains lowest first, one per clock
    fix_req = 8'b1001_0110;
    tick();
    fix_req = 8'h00;
    tick();
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(4);
    exp_q.push_back(7);
    drain(1'b0, 20, cycles);
    check("backlog_cycles",  32'(cycles),      32'd4);
    check("backlog_valid",   32'(fix_valid),   32'h0);
    check("backlog_pending", 32'(fix_pending), 32'h00);
    check("backlog_code_hold", 32'(fix_code),  32'd7);

    // 4. Stall holds selection even when a higher-priority request arrives
    fix_ready = 1'b0;
    fix_req   = 8'b0000_1000;
    tick();
    fix_req = 8'h00;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(fix_valid), 32'h1);
      check("stall_code",  32'(fix_code),  32'd3);
      fix_req = (i == 1) ? 8'h01 : 8'h00;
      tick();
    end
    fix_req = 8'h00;
    check("stall_code_after", 32'(fix_code),    32'd3);
    check("stall_pending",    32'(fix_pending), 32'h09);
    fix_ready = 1'b1;
    exp_q.push_back(3);
    exp_q.push_back(0);
    drain(1'b0, 10, cycles);
    check("stall_done_valid", 32'(fix_valid), 32'h0);

    // 5. Round robin with all requests held: 0..7,0,1 and re-pend on accept
    rr_req   = 8'hFF;
    rr_ready = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 10; k++) exp_q.push_back(k % 8);
    drain(1'b1, 30, cycles);
    check("rr_cycles",  32'(cycles),     32'd10);
    check("rr_pending", 32'(rr_pending), 32'hFF);
    check("rr_next",    32'(rr_code),    32'd2);
    rr_req   = 8'h00;
    rr_ready = 1'b0;

    // 6. Reset mid-handshake
    fix_ready = 1'b0;
    fix_req   = 8'hC0;
    tick();
    fix_req = 8'h00;
    tick();
    check("pre_rst_code",    32'(fix_code),    32'd6);
    check("pre_rst_pending", 32'(fix_pending), 32'hC0);
    check("pre_rst_valid",   32'(fix_valid),   32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_pending", 32'(fix_pending), 32'h00);
    check("mid_rst_valid",   32'(fix_valid),   32'h0);
    check("mid_rst_code",    32'(fix_code),    32'h0);
    check("mid_rst_rr_pending", 32'(rr_pending), 32'h00);
    check("mid_rst_rr_valid",   32'(rr_valid),   32'h0);
    // Round-robin pointer back at 0: index 1 wins over index 2
    rr_req = 8'h06;
    tick();
    rr_req = 8'h00;
    tick();
    check("rr_ptr_reset_code",  32'(rr_code),  32'd1);
    check("rr_ptr_reset_valid", 32'(rr_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
